cam_frame_capture: RTL

- Receiving end of the simulated/real camera pixel stream: one gray pixel per clock, plus one-cycle line-start and frame-start pulses.
- Assigns x/y coordinates and checks stream geometry against WIDTH/HEIGHT.
- Writes complete frames into a ping-pong frame buffer.
- Publishes each finished frame to the downstream stereo/census stage via a ready/ack handshake with a synchronous read port.

---
 rtl/stereo_cam_pkg.sv | 18 +
 rtl/pingpong_frame_ram.sv | 41 ++++
 rtl/cam_frame_capture.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/stereo_cam_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stereo_cam_pkg: shared widths and capture-state type for the camera front end
// Revision: 1.0
// ---------------------------------------------------------------------------
package stereo_cam_pkg;

  localparam int PIX_W_DEFAULT = 10;
  localparam int COORD_W       = 11;
  localparam int DROP_W        = 8;

  typedef enum logic [0:0] {
    SYNC    = 1'b0,
    CAPTURE = 1'b1
  } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/pingpong_frame_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pingpong_frame_ram: two frame banks; writes go to one bank, reads come from the other
// Revision: 1.0
// ---------------------------------------------------------------------------
module pingpong_frame_ram #(
  parameter int PIX_W  = 10,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_bank,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [PIX_W-1:0]  i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [PIX_W-1:0]  o_rd_data
);

  logic [PIX_W-1:0] r_bank0 [DEPTH];
  logic [PIX_W-1:0] r_bank1 [DEPTH];
  logic [PIX_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      if (i_wr_bank) r_bank1[i_wr_addr] <= i_wr_data;
      else           r_bank0[i_wr_addr] <= i_wr_data;
    end
  end

  // Read side always targets the bank not currently being written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd_data <= '0;
    else     r_rd_data <= i_wr_bank ? r_bank0[i_rd_addr] : r_bank1[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/cam_frame_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cam_frame_capture: geometry-checked pixel capture into a ping-pong buffer with publish handshake
// Revision: 1.0
// ---------------------------------------------------------------------------
module cam_frame_capture
  import stereo_cam_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEFAULT,
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int ADDR_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PIX_W-1:0]   iGray,
  input  logic               iLineClock,
  input  logic               iFrameClock,
  input  logic               iFrameAck,
  input  logic [ADDR_W-1:0]  iRdAddr,
  output logic [PIX_W-1:0]   oRdGray,
  output logic               oFrameReady,
  output logic               oPixValid,
  output logic [COORD_W-1:0] oX,
  output logic [COORD_W-1:0] oY,
  output logic               oLineErr,
  output logic               oFrameErr,
  output logic [DROP_W-1:0]  oDropCount
);

  localparam int                 DEPTH   = WIDTH * HEIGHT;
  localparam logic [COORD_W-1:0] C_ONE    = COORD_W'(1);
  localparam logic [COORD_W-1:0] C_WIDTH  = COORD_W'(WIDTH);
  localparam logic [COORD_W-1:0] C_LAST_X = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] C_LAST_Y = COORD_W'(HEIGHT - 1);
  localparam logic [DROP_W-1:0]  C_DROP_MAX = {DROP_W{1'b1}};

  cap_state_t          r_state, w_state_next;
  logic [COORD_W-1:0]  r_x, r_y, w_x_next, w_y_next;
  logic [COORD_W-1:0]  w_wx, w_wy;
  logic                w_we, w_line_err, w_frame_err, w_complete;
  logic                r_wb, w_wb_next;
  logic                r_ready, w_ready_next, w_ready_kept;
  logic [DROP_W-1:0]   r_drop, w_drop_next;
  logic                r_pix_valid, r_line_err, r_frame_err;
  logic [COORD_W-1:0]  r_ox, r_oy;
  logic [ADDR_W-1:0]   w_wr_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= SYNC;
      r_x         <= '0;
      r_y         <= '0;
      r_wb        <= 1'b0;
      r_ready     <= 1'b0;
      r_drop      <= '0;
      r_pix_valid <= 1'b0;
      r_ox        <= '0;
      r_oy        <= '0;
      r_line_err  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_x         <= w_x_next;
      r_y         <= w_y_next;
      r_wb        <= w_wb_next;
      r_ready     <= w_ready_next;
      r_drop      <= w_drop_next;
      r_pix_valid <= w_we;
      r_ox        <= w_wx;
      r_oy        <= w_wy;
      r_line_err  <= r_line_err | w_line_err;
      r_frame_err <= r_frame_err | w_frame_err;
    end
  end

  // Position tracking: r_x is the column the next plain pixel lands on.
  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_y_next     = r_y;
    w_we         = 1'b0;
    w_wx         = '0;
    w_wy         = '0;
    w_line_err   = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      SYNC: begin
        if (iFrameClock) begin
          w_we         = 1'b1;
          w_x_next     = C_ONE;
          w_y_next     = '0;
          w_state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (iFrameClock) begin
          w_frame_err = 1'b1;
          w_we        = 1'b1;
          w_x_next    = C_ONE;
          w_y_next    = '0;
        end else if (iLineClock) begin
          if (r_x == C_WIDTH && r_y < C_LAST_Y) begin
            w_we     = 1'b1;
            w_wy     = r_y + C_ONE;
            w_x_next = C_ONE;
            w_y_next = r_y + C_ONE;
          end else begin
            w_line_err   = 1'b1;
            w_state_next = SYNC;
          end
        end else if (r_x < C_WIDTH) begin
          w_we     = 1'b1;
          w_wx     = r_x;
          w_wy     = r_y;
          w_x_next = r_x + C_ONE;
        end else begin
          w_line_err   = 1'b1;
          w_state_next = SYNC;
        end
      end
      default: w_state_next = SYNC;
    endcase
    w_complete = w_we && (w_wx == C_LAST_X) && (w_wy == C_LAST_Y);
    if (w_complete) begin
      w_state_next = SYNC;
      w_x_next     = '0;
      w_y_next     = '0;
    end
  end

  // Ack is applied before a completion decides between publishing and dropping.
  always_comb begin
    w_ready_kept = r_ready & ~iFrameAck;
    w_ready_next = w_ready_kept;
    w_wb_next    = r_wb;
    w_drop_next  = r_drop;
    if (w_complete) begin
      if (!w_ready_kept) begin
        w_wb_next    = ~r_wb;
        w_ready_next = 1'b1;
      end else if (r_drop != C_DROP_MAX) begin
        w_drop_next = r_drop + DROP_W'(1);
      end
    end
  end

  assign w_wr_addr = ADDR_W'(w_wy * C_WIDTH + w_wx);

  pingpong_frame_ram #(
    .PIX_W  (PIX_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clock),
    .rst       (reset),
    .i_wr_bank (r_wb),
    .i_wr_en   (w_we),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (iGray),
    .i_rd_addr (iRdAddr),
    .o_rd_data (oRdGray)
  );

  assign oFrameReady = r_ready;
  assign oPixValid   = r_pix_valid;
  assign oX          = r_ox;
  assign oY          = r_oy;
  assign oLineErr    = r_line_err;
  assign oFrameErr   = r_frame_err;
  assign oDropCount  = r_drop;

endmodule
`default_nettype wire
